// File: rtl/vga_scroll_pattern_gen.sv
// vga_scroll_pattern_gen: scrolling stripe/checker/diagonal test pattern with registered, aligned syncs.
// Optional square-wave tone output when STRIPES_AUDIO_EN is defined.
module vga_scroll_pattern_gen #(
  parameter int unsigned OFFSET_W = 10,
  parameter int unsigned SPEED_W  = 4,
  parameter int unsigned FRAME_W  = 8,
  parameter int unsigned R_BIT    = 5,
  parameter int unsigned G_BIT    = 6,
  parameter int unsigned B_BIT    = 7,
  parameter int unsigned Y_LO     = 2,
  parameter int unsigned Y_HI     = 5,
  parameter int unsigned SYNC_POL = 0,
  parameter int unsigned TONE_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               display_on,
  input  logic [9:0]         pix_x,
  input  logic [9:0]         pix_y,
  input  logic [SPEED_W-1:0] speed,
  input  logic               dir,
  input  logic               pause,
  input  logic [1:0]         mode,
  output logic [1:0]         R,
  output logic [1:0]         G,
  output logic [1:0]         B,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               sound
);

  localparam logic SYNC_ACT = 1'(SYNC_POL);

  if (OFFSET_W < 10 || R_BIT < 1 || G_BIT < 1 || B_BIT < 1 || B_BIT >= OFFSET_W ||
      G_BIT >= OFFSET_W || R_BIT >= OFFSET_W || Y_LO > 9 || Y_HI > 9 || B_BIT > 9 ||
      TONE_W < 1) begin : g_param_check
    $error("vga_scroll_pattern_gen: illegal parameter combination");
  end

  logic [OFFSET_W-1:0] offset;
  logic [1:0]          mode_l;
  logic                vsync_d;
  logic                frame_tick;
  logic [OFFSET_W-1:0] mx, my, dd, speed_ext;
  logic [1:0]          r_c, g_c, b_c;
  logic                chk_c;

  // Frame start is the edge of vsync into its active level, seen in the pixel clock domain.
  assign frame_tick = (vsync_in == SYNC_ACT) && (vsync_d != SYNC_ACT);
  assign vsync_out  = vsync_d;
  assign speed_ext  = OFFSET_W'(speed);

  // Moving coordinates; the offset register already carries the scroll direction.
  always_comb begin
    mx    = OFFSET_W'(pix_x) + offset;
    my    = OFFSET_W'(pix_y) + offset;
    dd    = OFFSET_W'(pix_x) + OFFSET_W'(pix_y) + offset;
    chk_c = mx[B_BIT] ^ pix_y[B_BIT];
    r_c   = 2'b00;
    g_c   = 2'b00;
    b_c   = 2'b00;
    if (display_on) begin
      case (mode_l)
        2'd0: begin
          r_c = {mx[R_BIT], pix_y[Y_LO]};
          g_c = {mx[G_BIT], pix_y[Y_LO]};
          b_c = {mx[B_BIT], pix_y[Y_HI]};
        end
        2'd1: begin
          r_c = {my[R_BIT], pix_x[Y_LO]};
          g_c = {my[G_BIT], pix_x[Y_LO]};
          b_c = {my[B_BIT], pix_x[Y_HI]};
        end
        2'd2: begin
          r_c = {chk_c, chk_c};
          g_c = {chk_c, chk_c};
          b_c = {chk_c, chk_c};
        end
        default: begin
          r_c = {dd[R_BIT], dd[R_BIT-1]};
          g_c = {dd[G_BIT], dd[G_BIT-1]};
          b_c = {dd[B_BIT], dd[B_BIT-1]};
        end
      endcase
    end
  end

  // Pixel pipeline, sync delay and per-frame state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      R         <= 2'b00;
      G         <= 2'b00;
      B         <= 2'b00;
      hsync_out <= ~SYNC_ACT;
      vsync_d   <= ~SYNC_ACT;
      offset    <= '0;
      mode_l    <= 2'b00;
      frame_cnt <= '0;
    end else begin
      R         <= r_c;
      G         <= g_c;
      B         <= b_c;
      hsync_out <= hsync_in;
      vsync_d   <= vsync_in;
      if (frame_tick) begin
        mode_l    <= mode;
        frame_cnt <= frame_cnt + FRAME_W'(1);
        if (!pause)
          offset <= dir ? (offset - speed_ext) : (offset + speed_ext);
      end
    end
  end

`ifdef STRIPES_AUDIO_EN
  logic [SPEED_W-1:0] speed_l;
  logic               pause_l;
  logic [TONE_W-1:0]  acc;

  // Tone pitch follows the scroll speed latched at frame start; silent while paused.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      speed_l <= '0;
      pause_l <= 1'b0;
      acc     <= '0;
      sound   <= 1'b0;
    end else begin
      if (frame_tick) begin
        speed_l <= speed;
        pause_l <= pause;
      end
      if (pause_l) begin
        sound <= 1'b0;
      end else begin
        acc   <= acc + TONE_W'(speed_l) + TONE_W'(1);
        sound <= acc[TONE_W-1];
      end
    end
  end
`else
  assign sound = 1'b0;
`endif

endmodule
